// File: rtl/ledmx_pkg.sv
// Shared constants, FSM state type and row-search helper for the MAX7219 LED matrix streamer.
package ledmx_pkg;

  localparam logic [3:0] REG_DECODE       = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  localparam int unsigned INIT_WORDS    = 6;
  localparam logic [2:0]  SPI_DATA_ADDR = 3'd1;
  localparam logic [3:0]  NO_ROW        = 4'd8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_RDY,
    ST_WR,
    ST_GAP
  } state_e;

  // Lowest row index >= from whose mask bit is set, or NO_ROW if there is none.
  function automatic logic [3:0] next_row(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] idx;
    idx = NO_ROW;
    for (int unsigned i = 8; i > 0; i--) begin
      if (mask[3'(i - 1)] && (4'(i - 1) >= from)) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ledmx_word_writer.sv
// Hands one 16-bit word to the downstream SPI master: wait for TRDY, 2-cycle write, 2-cycle gap.
module ledmx_word_writer
  import ledmx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] word_i,
  input  logic        trdy_i,
  output logic        select_o,
  output logic        write_n_o,
  output logic [15:0] data_o,
  output logic        done_o
);

  state_e      state_q;
  logic        phase_q;
  logic        select_q;
  logic        write_n_q;
  logic [15:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      select_q  <= 1'b0;
      write_n_q <= 1'b1;
      data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            data_q  <= word_i;
            state_q <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (trdy_i) begin
            state_q   <= ST_WR;
            select_q  <= 1'b1;
            write_n_q <= 1'b0;
            phase_q   <= 1'b0;
          end
        end
        ST_WR: begin
          if (phase_q) begin
            state_q   <= ST_GAP;
            select_q  <= 1'b0;
            write_n_q <= 1'b1;
            phase_q   <= 1'b0;
          end else begin
            phase_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_q) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
          end else begin
            phase_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          select_q  <= 1'b0;
          write_n_q <= 1'b1;
          phase_q   <= 1'b0;
        end
      endcase
    end
  end

  assign select_o  = select_q;
  assign write_n_o = write_n_q;
  assign data_o    = data_q;
  // Done in the final GAP cycle so the caller can launch the next word without a bubble.
  assign done_o    = (state_q == ST_GAP) && phase_q;

endmodule

// File: rtl/spi_led_matrix_streamer.sv
// Streams an 8x8 row buffer to a MAX7219 through an SPI master control port, after a 6-word init.
// Optional LEDMX_DIRTY_TRACK_EN: only rows written since they were last sent go out in a frame.
module spi_led_matrix_streamer #(
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned SCAN_LIMIT     = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        row_wr,
  input  logic [2:0]  row_addr,
  input  logic [7:0]  row_data,
  input  logic [3:0]  intensity,
  output logic        spi_select,
  output logic        spi_write_n,
  output logic [2:0]  spi_mem_addr,
  output logic [15:0] spi_data,
  input  logic        spi_readyfordata,
  output logic        busy,
  output logic        frame_done
);

  import ledmx_pkg::*;

  localparam int unsigned    CNT_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  state_e           state_q;
  logic [2:0]       init_q;
  logic [3:0]       seq_q;
  logic [3:0]       last_int_q;
  logic [7:0]       row_buf_q [8];
  logic [CNT_W-1:0] refresh_q;
  logic             frame_done_q;

  logic        expire;
  logic        int_changed;
  logic [2:0]  row_idx;
  logic [7:0]  send_mask;
  logic [3:0]  first_row;
  logic [3:0]  nxt_row;
  logic        start_c;
  logic [15:0] word_c;
  logic        wr_done;

  assign expire      = (refresh_q == '0);
  assign int_changed = (intensity != last_int_q);
  // seq_q == 0 is the intensity slot; seq_q == n (1..8) carries row n-1.
  assign row_idx     = 3'(seq_q - 4'd1);

`ifdef LEDMX_DIRTY_TRACK_EN
  logic [7:0] dirty_q;
  logic [7:0] dirty_d;

  always_comb begin
    dirty_d = dirty_q;
    if (state_q == ST_LOAD && seq_q != 4'd0) dirty_d[row_idx] = 1'b0;
    if (row_wr) dirty_d[row_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dirty_q <= '0;
    else          dirty_q <= dirty_d;
  end

  assign send_mask = dirty_d;
`else
  assign send_mask = '1;
`endif

  assign first_row = next_row(send_mask, 4'd0);
  assign nxt_row   = next_row(send_mask, seq_q);

  always_comb begin
    start_c = 1'b0;
    word_c  = '0;
    case (state_q)
      ST_INIT: begin
        start_c = 1'b1;
        case (init_q)
          3'd0:    word_c = {4'h0, REG_SHUTDOWN, 8'h00};
          3'd1:    word_c = {4'h0, REG_DISPLAY_TEST, 8'h00};
          3'd2:    word_c = {4'h0, REG_DECODE, 8'h00};
          3'd3:    word_c = {4'h0, REG_SCAN_LIMIT, 5'b0, 3'(SCAN_LIMIT)};
          3'd4:    word_c = {4'h0, REG_INTENSITY, 4'h0, intensity};
          default: word_c = {4'h0, REG_SHUTDOWN, 8'h01};
        endcase
      end
      ST_LOAD: begin
        start_c = 1'b1;
        if (seq_q == 4'd0) word_c = {4'h0, REG_INTENSITY, 4'h0, intensity};
        else               word_c = {4'h0, seq_q, row_buf_q[row_idx]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_q       <= '0;
      seq_q        <= '0;
      last_int_q   <= '0;
      refresh_q    <= CNT_RELOAD;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) row_buf_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      refresh_q    <= expire ? CNT_RELOAD : refresh_q - 1'b1;
      if (row_wr) row_buf_q[row_addr] <= row_data;

      case (state_q)
        ST_INIT: begin
          if (init_q == 3'd4) last_int_q <= intensity;
          state_q <= ST_WAIT_RDY;
        end
        ST_IDLE: begin
          if (expire) begin
            if (int_changed) begin
              seq_q   <= '0;
              state_q <= ST_LOAD;
            end else if (first_row != NO_ROW) begin
              seq_q   <= first_row + 4'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (seq_q == 4'd0) last_int_q <= intensity;
          state_q <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (wr_done) begin
            if (init_q != 3'(INIT_WORDS)) begin
              init_q  <= init_q + 3'd1;
              state_q <= (init_q == 3'(INIT_WORDS - 1)) ? ST_IDLE : ST_INIT;
            end else if (nxt_row == NO_ROW) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              seq_q   <= nxt_row + 4'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  ledmx_word_writer u_writer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .start_i   (start_c),
    .word_i    (word_c),
    .trdy_i    (spi_readyfordata),
    .select_o  (spi_select),
    .write_n_o (spi_write_n),
    .data_o    (spi_data),
    .done_o    (wr_done)
  );

  assign spi_mem_addr = SPI_DATA_ADDR;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_spi_led_matrix_streamer.sv
// Randomized bench for spi_led_matrix_streamer against a frame-level model of the row buffer.
module tb_spi_led_matrix_streamer;

  localparam int unsigned R = 300;
`ifdef LEDMX_DIRTY_TRACK_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        row_wr = 1'b0;
  logic [2:0]  row_addr = '0;
  logic [7:0]  row_data = '0;
  logic [3:0]  intensity = 4'h5;
  logic        spi_readyfordata = 1'b1;
  logic        spi_select, spi_write_n, busy, frame_done;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data;

  always #5 clk = ~clk;

  spi_led_matrix_streamer #(.REFRESH_CYCLES(R), .SCAN_LIMIT(7)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .row_wr           (row_wr),
    .row_addr         (row_addr),
    .row_data         (row_data),
    .intensity        (intensity),
    .spi_select       (spi_select),
    .spi_write_n      (spi_write_n),
    .spi_mem_addr     (spi_mem_addr),
    .spi_data         (spi_data),
    .spi_readyfordata (spi_readyfordata),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int fd_count = 0;
  int sel_cycles = 0;
  int cyc = 0;
  bit stall = 1'b0;

  logic [15:0] obs[$];
  logic [15:0] expq[$];
  logic [7:0]  m_buf [8];
  logic [7:0]  m_dirty;
  logic [3:0]  m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus monitor: reconstructs handed-off words from write strobes.
  int run_len = 0;
  int gap_len = 0;
  bit seen_run = 1'b0;
  logic [15:0] run_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      run_len = 0; gap_len = 0; seen_run = 1'b0;
    end else begin
      chk("sel_vs_wn", 32'(spi_select), 32'(!spi_write_n));
      if (frame_done) fd_count++;
      if (spi_select) begin
        sel_cycles++;
        if (run_len == 0) begin
          if (seen_run) chk("gap_len_min", 32'(gap_len >= 2), 32'd1);
          run_data = spi_data;
        end else begin
          chk("wr_data_stable", 32'(spi_data), 32'(run_data));
        end
        run_len++;
      end else begin
        if (run_len > 0) begin
          chk("wr_len", run_len, 2);
          obs.push_back(run_data);
          seen_run = 1'b1;
          gap_len = 0;
        end
        gap_len++;
        run_len = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset_n) cyc = 0;
    else          cyc++;
  end

  initial begin
    forever begin
      @(negedge clk);
      spi_readyfordata = stall ? 1'b0 : ($urandom_range(0, 9) < 8);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_buf[i] = '0;
    m_dirty = '0;
    m_last  = '0;
  endtask

  task automatic write_row(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    row_wr = 1'b1; row_addr = a; row_data = d;
    m_buf[a] = d;
    m_dirty[a] = 1'b1;
    @(negedge clk);
    row_wr = 1'b0;
  endtask

  // Keep host activity well clear of refresh expiries.
  task automatic wait_safe();
    int t = 0;
    while ((((cyc % R) < 20) || ((cyc % R) > (R - 60))) && t < 4 * R) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_init(input int fd_base);
    logic [15:0] ie [6];
    int t = 0;
    ie = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0B07, {8'h0A, 4'h0, intensity}, 16'h0C01};
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("init_busy_clear", 32'(busy), 32'd0);
    chk("init_count", obs.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < obs.size()) chk($sformatf("init_word%0d", i), 32'(obs[i]), 32'(ie[i]));
    chk("init_no_fd", fd_count - fd_base, 0);
    m_last = intensity;
  endtask

  task automatic build_expected();
    expq.delete();
    if (intensity != m_last) begin
      expq.push_back({8'h0A, 4'h0, intensity});
      m_last = intensity;
    end
    for (int r = 0; r < 8; r++)
      if (!DIRTY || m_dirty[r]) expq.push_back({4'h0, 4'(r + 1), m_buf[r]});
    m_dirty = '0;
  endtask

  task automatic run_frame();
    int base = fd_count;
    int t = 0;
    build_expected();
    if (expq.size() == 0) begin
      repeat (2 * R) @(negedge clk);
      chk("idle_words", obs.size(), 0);
      chk("idle_fd", fd_count - base, 0);
    end else begin
      while (fd_count == base && t < 3 * R) begin
        @(negedge clk);
        t++;
      end
      chk("frame_seen", 32'(fd_count != base), 32'd1);
      repeat (2) @(negedge clk);
      chk("fd_pulses", fd_count - base, 1);
      chk("frame_len", obs.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
        if (i < obs.size()) chk($sformatf("frame_word%0d", i), 32'(obs[i]), 32'(expq[i]));
    end
  endtask

  task automatic stall_probe();
    int t = 0;
    int s0, n0;
    while (!busy && t < 2 * R) begin
      @(negedge clk);
      t++;
    end
    stall = 1'b1;
    s0 = sel_cycles;
    n0 = obs.size();
    repeat (100) @(negedge clk);
    chk("stall_sel", sel_cycles - s0, 0);
    chk("stall_words", obs.size() - n0, 0);
    stall = 1'b0;
  endtask

  initial begin
    int t;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(spi_select), 32'd0);
    chk("rst_wn", 32'(spi_write_n), 32'd1);
    chk("rst_addr", 32'(spi_mem_addr), 32'd1);
    chk("rst_data", 32'(spi_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    do_init(fd_count);

    for (int it = 0; it < 12; it++) begin
      obs.delete();
      wait_safe();
      case (it)
        0: for (int r = 0; r < 8; r++) write_row(3'(r), (r == 3) ? 8'hA5 : 8'($urandom));
        1: begin
          intensity = 4'h9;
          repeat ($urandom_range(0, 3)) write_row(3'($urandom_range(0, 7)), 8'($urandom));
        end
        2: begin
          write_row(3'd2, 8'($urandom));
          write_row(3'd6, 8'($urandom));
        end
        3: ;
        4: repeat (2) write_row(3'($urandom_range(0, 7)), 8'($urandom));
        default: begin
          if ($urandom_range(0, 2) == 0) intensity = 4'($urandom_range(0, 15));
          repeat ($urandom_range(0, 4)) write_row(3'($urandom_range(0, 7)), 8'($urandom));
        end
      endcase
      if (it == 4) begin
        fork
          run_frame();
          stall_probe();
        join
      end else begin
        run_frame();
      end
      if (it == 0 && obs.size() > 3) chk("row3_word", 32'(obs[3]), 32'h04A5);
      if (it == 1 && obs.size() > 0) chk("int_word", 32'(obs[0]), 32'h0A09);
    end

    // Asynchronous reset in the middle of a row write, then init must replay.
    obs.delete();
    wait_safe();
    write_row(3'd5, 8'($urandom));
    t = 0;
    while (spi_write_n && t < 3 * R) begin
      @(negedge clk);
      t++;
    end
    chk("rst_wr_reached", 32'(spi_write_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_wn", 32'(spi_write_n), 32'd1);
    chk("rst_async_sel", 32'(spi_select), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    obs.delete();
    model_reset();
    reset_n = 1'b1;
    do_init(fd_count);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/spi_led_matrix_streamer.md
SPI_LED_MATRIX_STREAMER -- requirements
Module: spi_led_matrix_streamer

Interface
REQ-001 Parameter: REFRESH_CYCLES, 50000, clk cycles between frame-start opportunities (≥16).
REQ-002 Parameter: SCAN_LIMIT, 7, value sent to MAX7219 scan-limit register 0x0B (3 bits).
REQ-003 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: row_wr  in  1  one-cycle strobe writing row_data into the row buffer at row_addr.
REQ-006 Port: row_addr  in  3  row index 0..7.
REQ-007 Port: row_data  in  8  column bitmap, bit 7 = leftmost LED.
REQ-008 Port: intensity  in  4  MAX7219 brightness, sampled continuously.
REQ-009 Port: spi_select  out  1  chip-select to the downstream SPI master control port.
REQ-010 Port: spi_write_n  out  1  active-low write to the SPI master.
REQ-011 Port: spi_mem_addr  out  3  SPI master register address; always 3'd1 (write data).
REQ-012 Port: spi_data  out  16  word to transmit: {4'h0, reg_addr[3:0], value[7:0]}.
REQ-013 Port: spi_readyfordata  in  1  TRDY from the SPI master.
REQ-014 Port: busy  out  1  high while the init sequence or a frame is in progress.
REQ-015 Port: frame_done  out  1  one-cycle pulse after the last word of a frame is handed off.

Function
REQ-016 FSM states: INIT, IDLE, LOAD, WAIT_RDY, WR, GAP; after reset the FSM SHALL start in INIT.
REQ-017 INIT SHALL issue exactly six words in order: 0x0C00, 0x0F00, 0x0900, {0x0B, 5'b0, SCAN_LIMIT}, {0x0A, 4'b0, intensity}, 0x0C01, then enter IDLE.
REQ-018 Word handshake: in WAIT_RDY, when spi_readyfordata=1, assert spi_select=1 and spi_write_n=0 with stable spi_data for exactly 2 cycles (WR), then deassert both for exactly 2 cycles (GAP), because the master's TRDY lags a write by 2 cycles.
REQ-019 Outside WR, spi_select=0 and spi_write_n=1; spi_data holds its last value.
REQ-020 A 32-bit-free refresh counter SHALL count REFRESH_CYCLES-1 down to 0 and reload; a frame SHALL start at expiry only if the FSM is in IDLE, otherwise that expiry is dropped.
REQ-021 Frame content: if intensity differs from the last sent value, first word {0x0A, 4'b0, intensity}; then rows 0..7 ascending as {4'h0, row+1, row_buf[row]}.
REQ-022 Row data SHALL be sampled from the row buffer in LOAD (the cycle the word is formed), not at frame start.
REQ-023 row_wr SHALL update the row buffer in the same cycle regardless of FSM state; a write to the row currently being loaded takes effect for the next frame.
REQ-024 frame_done SHALL pulse in the cycle GAP ends for the last word of a frame; never during INIT.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 If spi_readyfordata stays 0 the FSM SHALL wait in WAIT_RDY indefinitely; no timeout, no word dropped.

Reset
REQ-027 On reset_n=0: FSM to INIT at word 0, spi_select=0, spi_write_n=1, spi_mem_addr=1, spi_data=0, busy=1, frame_done=0, row buffer all 0, last-intensity register 0, refresh counter REFRESH_CYCLES-1, dirty bits 0.
REQ-028 Reset asserted mid-word SHALL release spi_select/spi_write_n immediately (asynchronous) and restart INIT from word 0 on release.

Configuration
REQ-029 Macro LEDMX_DIRTY_TRACK_EN: when defined, an 8-bit dirty mask is kept; row_wr sets its bit, LOAD of that row clears it (row_wr in the same cycle wins, bit stays set); a frame sends only dirty rows plus the intensity word if changed, and a frame with nothing to send SHALL not start (no frame_done).
REQ-030 Without LEDMX_DIRTY_TRACK_EN every frame sends all 8 rows; no dirty mask exists.

Structure
REQ-031 Package ledmx_pkg: MAX7219 register address constants (0x09, 0x0A, 0x0B, 0x0C, 0x0F), FSM state enum, init-word count constant, SPI data-register address constant 3'd1.
REQ-032 One sub-module, ledmx_word_writer, owns WAIT_RDY/WR/GAP and the SPI-master port signals, with a start/word input and a done pulse.

Verification
REQ-033 Reset release, spi_readyfordata=1, intensity=4'h5 -> words 0x0C00,0x0F00,0x0900,0x0B07,0x0A05,0x0C01 each with exactly 2 write cycles and 2 gap cycles, then busy=0.
REQ-034 row_buf[3]=0xA5, full frame -> 4th row word 0x04A5; 8 row words total, intensity unchanged so no 0x0A word; frame_done one pulse.
REQ-035 spi_readyfordata held 0 for 100 cycles during a frame -> spi_select stays 0, then word sent once when TRDY returns; none lost or duplicated.
REQ-036 intensity 5->9 between frames -> next frame begins with 0x0A09.
REQ-037 With LEDMX_DIRTY_TRACK_EN: write rows 2 and 6 only -> frame sends 0x0300|d2 and 0x0700|d6 only; next expiry with no writes -> no words, no frame_done.
REQ-038 reset_n pulsed low during WR of a row word -> spi_write_n=1 within the same cycle; after release the 6-word init replays.
